// File: rtl/reg_access_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// reg_access_ctrl_pkg
//  Shared types for the register access front-end:
//   op_e    - read-modify-write operation encodings carried on req_op
//   state_e - request sequencing states (idle / execute / respond)
// ----------------------------------------------------------------------------
package reg_access_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_WRITE  = 2'b00,
        OP_SET    = 2'b01,
        OP_CLEAR  = 2'b10,
        OP_TOGGLE = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_e;

endpackage : reg_access_ctrl_pkg

// File: rtl/reg_access_ctrl_alu.sv
// ----------------------------------------------------------------------------
// reg_op_alu
//  Combinational next-value calculation for one read-modify-write op.
//  Ports:
//   op        in   op_e    operation to apply
//   old_value in   WIDTH   current register contents
//   wdata     in   WIDTH   operand
//   nv        out  WIDTH   resulting register value
// ----------------------------------------------------------------------------
module reg_op_alu
    import reg_access_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] old_value,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] nv
);

    always_comb begin
        // NOTE: assign a default before the case so every path drives nv;
        // otherwise synthesis infers a latch for the uncovered paths.
        nv = wdata;
        case (op)
            OP_WRITE:  nv = wdata;
            OP_SET:    nv = old_value | wdata;
            OP_CLEAR:  nv = old_value & ~wdata;
            OP_TOGGLE: nv = old_value ^ wdata;
        endcase
    end

endmodule : reg_op_alu

// File: rtl/reg_access_ctrl.sv
// ----------------------------------------------------------------------------
// reg_access_ctrl
//  Front-end for a bank of NUM_REGS registers. Accepts one request on a
//  valid/ready channel, reads the target register, applies the op and pulses
//  that register's update strobe for one cycle with the shared new_value.
//  The pre-op value (or an error flag) is returned on a valid/ready channel.
//  Ports:
//   clk, rst_n       clock (posedge), async active-low reset
//   req_valid/ready  request handshake; req_write/op/addr/wdata sampled at accept
//   rsp_valid/ready  response handshake; rsp_rdata = pre-op value, rsp_err = bad addr
//   update           one-hot write strobe, one bit per register
//   new_value        shared next value for the strobed register
//   curr_value_flat  register outputs, reg i at [i*WIDTH +: WIDTH]
// ----------------------------------------------------------------------------
module reg_access_ctrl
    import reg_access_ctrl_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int NUM_REGS   = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [1:0]                req_op,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [WIDTH-1:0]          req_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [WIDTH-1:0]          rsp_rdata,
    output logic                      rsp_err,
    output logic [NUM_REGS-1:0]       update,
    output logic [WIDTH-1:0]          new_value,
    input  logic [NUM_REGS*WIDTH-1:0] curr_value_flat
);

    // One extra bit so NUM_REGS == 2**ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0] NUM_REGS_L = (ADDR_WIDTH + 1)'(NUM_REGS);

    state_e                state;
    logic                  cap_write;
    op_e                   cap_op;
    logic [ADDR_WIDTH-1:0] cap_addr;
    logic [WIDTH-1:0]      cap_wdata;

    logic                  addr_ok;
    logic [WIDTH-1:0]      old_value;
    logic [NUM_REGS-1:0]   strobe;
    logic [WIDTH-1:0]      nv;

    // Everything below works on the captured request, never on live req_*,
    // so later changes on the request bus cannot leak into the operation.
    assign addr_ok = {1'b0, cap_addr} < NUM_REGS_L;

    // Out-of-range addresses select nothing: old_value stays 0, no strobe.
    always_comb begin
        old_value = '0;
        strobe    = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_ok && cap_addr == ADDR_WIDTH'(i)) begin
                old_value = curr_value_flat[i*WIDTH +: WIDTH];
                strobe[i] = cap_write;
            end
        end
    end

    reg_op_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .op        (cap_op),
        .old_value (old_value),
        .wdata     (cap_wdata),
        .nv        (nv)
    );

    // NOTE: sequential state uses non-blocking (<=) so every register sees
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            update    <= '0;
            new_value <= '0;
            cap_write <= 1'b0;
            cap_op    <= OP_WRITE;
            cap_addr  <= '0;
            cap_wdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        cap_write <= req_write;
                        cap_op    <= op_e'(req_op);
                        cap_addr  <= req_addr;
                        cap_wdata <= req_wdata;
                        req_ready <= 1'b0;
                        state     <= ST_EXEC;
                    end
                end

                ST_EXEC: begin
                    rsp_rdata <= old_value;
                    rsp_err   <= ~addr_ok;
                    update    <= strobe;
                    // new_value only moves with a strobe; otherwise it holds.
                    if (|strobe) begin
                        new_value <= nv;
                    end
                    rsp_valid <= 1'b1;
                    state     <= ST_RESP;
                end

                ST_RESP: begin
                    // The strobe lasts exactly the first response cycle.
                    update <= '0;
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    update    <= '0;
                end
            endcase
        end
    end

endmodule : reg_access_ctrl

// File: tb/tb_reg_access_ctrl.sv
// ----------------------------------------------------------------------------
// tb_reg_access_ctrl
//  Directed bench for reg_access_ctrl with WIDTH=4, NUM_REGS=3, ADDR_WIDTH=2.
//  A small behavioural register bank responds to update/new_value.
// ----------------------------------------------------------------------------
module tb_reg_access_ctrl;
    import reg_access_ctrl_pkg::*;

    localparam int WIDTH      = 4;
    localparam int NUM_REGS   = 3;
    localparam int ADDR_WIDTH = 2;

    logic                      clk;
    logic                      rst_n;
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_write;
    logic [1:0]                req_op;
    logic [ADDR_WIDTH-1:0]     req_addr;
    logic [WIDTH-1:0]          req_wdata;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [WIDTH-1:0]          rsp_rdata;
    logic                      rsp_err;
    logic [NUM_REGS-1:0]       update;
    logic [WIDTH-1:0]          new_value;
    logic [NUM_REGS*WIDTH-1:0] curr_value_flat;

    logic [WIDTH-1:0] bank [NUM_REGS];
    int               upd_cycles;
    int               multi_hot;
    int               n_checks;
    int               n_fail;
    logic [WIDTH-1:0] last_nv;

    reg_access_ctrl #(
        .WIDTH      (WIDTH),
        .NUM_REGS   (NUM_REGS),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_op          (req_op),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_rdata       (rsp_rdata),
        .rsp_err         (rsp_err),
        .update          (update),
        .new_value       (new_value),
        .curr_value_flat (curr_value_flat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register bank model: takes new_value on the edge where its strobe is high.
    // It has no reset of its own, so a controller reset cannot clear it.
    always @(posedge clk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (update[i] === 1'b1) bank[i] <= new_value;
        end
        if (update !== '0) upd_cycles++;
        if ($countones(update) > 1) multi_hot++;
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) curr_value_flat[i*WIDTH +: WIDTH] = bank[i];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One request, entered and left just after a falling edge. exp_nv is
    // only compared when exp_strobe is non-zero; otherwise new_value must hold.
    task automatic do_req(input string tag, input logic wr, input logic [1:0] op,
                          input logic [ADDR_WIDTH-1:0] addr, input logic [WIDTH-1:0] wd,
                          input logic [WIDTH-1:0] exp_rdata, input logic exp_err,
                          input logic [NUM_REGS-1:0] exp_strobe,
                          input logic [WIDTH-1:0] exp_nv, input int hold);
        int upd_before;
        upd_before = upd_cycles;
        check({tag, ".ready_idle"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_write = wr;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        @(posedge clk);                 // acceptance edge
        @(negedge clk);
        // Scramble the request bus: the captured copy must be used.
        req_valid = 1'b0;
        req_write = ~wr;
        req_op    = ~op;
        req_addr  = addr ^ 2'b01;
        req_wdata = ~wd;
        check({tag, ".exec_ready"}, 32'(req_ready), 32'd0);
        check({tag, ".exec_update"}, 32'(update), 32'd0);
        check({tag, ".exec_rsp_valid"}, 32'(rsp_valid), 32'd0);
        @(negedge clk);                 // after the execute edge
        check({tag, ".strobe"}, 32'(update), 32'(exp_strobe));
        if (exp_strobe != '0) last_nv = exp_nv;
        check({tag, ".new_value"}, 32'(new_value), 32'(last_nv));
        check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, ".rdata"}, 32'(rsp_rdata), 32'(exp_rdata));
        check({tag, ".err"}, 32'(rsp_err), 32'(exp_err));
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            check({tag, ".hold_valid"}, 32'(rsp_valid), 32'd1);
            check({tag, ".hold_rdata"}, 32'(rsp_rdata), 32'(exp_rdata));
            check({tag, ".hold_err"}, 32'(rsp_err), 32'(exp_err));
            check({tag, ".hold_ready"}, 32'(req_ready), 32'd0);
            check({tag, ".hold_update"}, 32'(update), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);                 // after the handshake edge
        rsp_ready = 1'b0;
        check({tag, ".done_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, ".done_ready"}, 32'(req_ready), 32'd1);
        check({tag, ".done_update"}, 32'(update), 32'd0);
        check({tag, ".strobe_cycles"}, 32'(upd_cycles - upd_before),
              (exp_strobe != '0) ? 32'd1 : 32'd0);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        upd_cycles = 0;
        multi_hot  = 0;
        last_nv    = '0;
        for (int i = 0; i < NUM_REGS; i++) bank[i] = '0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_op    = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset.req_ready", 32'(req_ready), 32'd1);
        check("reset.rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset.update", 32'(update), 32'd0);
        check("reset.new_value", 32'(new_value), 32'd0);
        check("reset.rsp_err", 32'(rsp_err), 32'd0);
        @(negedge clk);

        // rsp_ready without a response pending does nothing.
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("idle_rsp_ready.valid", 32'(rsp_valid), 32'd0);
        check("idle_rsp_ready.req_ready", 32'(req_ready), 32'd1);

        do_req("write_r1",  1'b1, OP_WRITE,  2'd1, 4'hA, 4'h0, 1'b0, 3'b010, 4'hA, 0);
        check("bank1_after_write", 32'(bank[1]), 32'hA);
        do_req("set_r1",    1'b1, OP_SET,    2'd1, 4'h5, 4'hA, 1'b0, 3'b010, 4'hF, 0);
        check("bank1_after_set", 32'(bank[1]), 32'hF);
        do_req("clear_r1",  1'b1, OP_CLEAR,  2'd1, 4'h3, 4'hF, 1'b0, 3'b010, 4'hC, 0);
        check("bank1_after_clear", 32'(bank[1]), 32'hC);
        do_req("toggle_r1", 1'b1, OP_TOGGLE, 2'd1, 4'hF, 4'hC, 1'b0, 3'b010, 4'h3, 0);
        check("bank1_after_toggle", 32'(bank[1]), 32'h3);
        do_req("write_r2",  1'b1, OP_WRITE,  2'd2, 4'h6, 4'h0, 1'b0, 3'b100, 4'h6, 0);
        check("bank2_after_write", 32'(bank[2]), 32'h6);

        // Out of range: no strobe, error, zero data; new_value holds at 6.
        do_req("write_oor", 1'b1, OP_WRITE,  2'd3, 4'h7, 4'h0, 1'b1, 3'b000, 4'h0, 0);
        do_req("read_oor",  1'b0, OP_WRITE,  2'd3, 4'h0, 4'h0, 1'b1, 3'b000, 4'h0, 0);
        // Read ignores op: no strobe, returns the stored value.
        do_req("read_r2",   1'b0, OP_TOGGLE, 2'd2, 4'hF, 4'h6, 1'b0, 3'b000, 4'h0, 0);
        check("bank2_after_read", 32'(bank[2]), 32'h6);

        // Backpressure: response held for 5 cycles.
        do_req("bp_write_r0", 1'b1, OP_WRITE, 2'd0, 4'h9, 4'h0, 1'b0, 3'b001, 4'h9, 5);
        check("bank0_after_bp", 32'(bank[0]), 32'h9);

        // Reset during EXEC: strobe cancelled, no response.
        begin
            int upd_before;
            upd_before = upd_cycles;
            req_valid = 1'b1;
            req_write = 1'b1;
            req_op    = OP_WRITE;
            req_addr  = 2'd0;
            req_wdata = 4'h5;
            @(posedge clk);
            @(negedge clk);
            req_valid = 1'b0;
            rst_n     = 1'b0;
            #1;
            check("midrst.req_ready", 32'(req_ready), 32'd1);
            check("midrst.rsp_valid", 32'(rsp_valid), 32'd0);
            check("midrst.update", 32'(update), 32'd0);
            check("midrst.new_value", 32'(new_value), 32'd0);
            check("midrst.rsp_rdata", 32'(rsp_rdata), 32'd0);
            check("midrst.rsp_err", 32'(rsp_err), 32'd0);
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            repeat (3) @(negedge clk);
            check("midrst.no_response", 32'(rsp_valid), 32'd0);
            check("midrst.no_strobe", 32'(upd_cycles - upd_before), 32'd0);
            check("midrst.bank0_kept", 32'(bank[0]), 32'h9);
            last_nv = '0;
        end

        // Recovery after reset.
        do_req("read_r0_after_rst", 1'b0, OP_WRITE, 2'd0, 4'h0, 4'h9, 1'b0, 3'b000, 4'h0, 0);

        check("never_multi_hot", 32'(multi_hot), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_reg_access_ctrl
